// File: rtl/systolic_feeder_if.sv
// Operand-store write ports, start control and skewed operand/status outputs
// that connect the systolic feeder to its controller and MAC array.
interface systolic_feeder_if #(
    parameter int N      = 4,
    parameter int DATA_W = 8,
    parameter int ADDR_W = $clog2(N*N)
);
    logic                  a_we;
    logic [ADDR_W-1:0]     a_waddr;
    logic [DATA_W-1:0]     a_wdata;
    logic                  b_we;
    logic [ADDR_W-1:0]     b_waddr;
    logic [DATA_W-1:0]     b_wdata;
    logic                  start;
    logic [N*DATA_W-1:0]   a_out;
    logic [N*DATA_W-1:0]   b_out;
    logic                  macc_clear;
    logic                  busy;
    logic                  done;

    modport master (
        output a_we, a_waddr, a_wdata, b_we, b_waddr, b_wdata, start,
        input  a_out, b_out, macc_clear, busy, done
    );

    modport slave (
        input  a_we, a_waddr, a_wdata, b_we, b_waddr, b_wdata, start,
        output a_out, b_out, macc_clear, busy, done
    );
endinterface

// File: rtl/systolic_feeder.sv
// Holds matrices A and B and streams them diagonally skewed into an NxN
// output-stationary MAC array: clear, feed 2N-1 wavefronts, drain N, done.
module systolic_feeder #(
    parameter int N      = 4,
    parameter int DATA_W = 8,
    parameter int ADDR_W = $clog2(N*N)
) (
    input  logic             clk,
    input  logic             rst,
    systolic_feeder_if.slave bus
);
    localparam int CNT_W = $clog2(2*N);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_CLEAR = 3'd1,
        S_FEED  = 3'd2,
        S_DRAIN = 3'd3,
        S_DONE  = 3'd4
    } state_e;

    state_e              state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [DATA_W-1:0]   a_mem_q [N*N];
    logic [DATA_W-1:0]   b_mem_q [N*N];
    logic [N*DATA_W-1:0] a_out_q, a_out_d;
    logic [N*DATA_W-1:0] b_out_q, b_out_d;
    logic                macc_clear_q, macc_clear_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;

    assign bus.a_out      = a_out_q;
    assign bus.b_out      = b_out_q;
    assign bus.macc_clear = macc_clear_q;
    assign bus.busy       = busy_q;
    assign bus.done       = done_q;

    // Operand stores: not reset, writable only while idle
    always_ff @(posedge clk) begin
        if (bus.a_we && (state_q == S_IDLE)) begin
            a_mem_q[bus.a_waddr] <= bus.a_wdata;
        end
        if (bus.b_we && (state_q == S_IDLE)) begin
            b_mem_q[bus.b_waddr] <= bus.b_wdata;
        end
    end

    // Sequencer next state and phase counter
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            S_IDLE: begin
                cnt_d = '0;
                if (bus.start) begin
                    state_d = S_CLEAR;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_CLEAR: begin
                state_d = S_FEED;
                cnt_d   = '0;
            end
            S_FEED: begin
                if (cnt_q == CNT_W'(2*N-2)) begin
                    state_d = S_DRAIN;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            S_DRAIN: begin
                if (cnt_q == CNT_W'(N-1)) begin
                    state_d = S_DONE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
                cnt_d   = '0;
            end
            default: begin
                state_d = S_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // Outputs are computed from the upcoming state so they register in step with it;
    // lane i carries element k = t - i of its row/column, zero outside the wavefront.
    always_comb begin
        a_out_d      = '0;
        b_out_d      = '0;
        macc_clear_d = (state_d == S_CLEAR);
        busy_d       = (state_d != S_IDLE);
        done_d       = (state_d == S_DONE);
        if (state_d == S_FEED) begin
            for (int i = 0; i < N; i++) begin
                if ((int'(cnt_d) >= i) && ((int'(cnt_d) - i) < N)) begin
                    a_out_d[i*DATA_W +: DATA_W] = a_mem_q[ADDR_W'(i*N + int'(cnt_d) - i)];
                    b_out_d[i*DATA_W +: DATA_W] = b_mem_q[ADDR_W'((int'(cnt_d) - i)*N + i)];
                end else begin
                    a_out_d[i*DATA_W +: DATA_W] = '0;
                    b_out_d[i*DATA_W +: DATA_W] = '0;
                end
            end
        end else begin
            a_out_d = '0;
            b_out_d = '0;
        end
    end

    // State and registered outputs with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= S_IDLE;
            cnt_q        <= '0;
            a_out_q      <= '0;
            b_out_q      <= '0;
            macc_clear_q <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            a_out_q      <= a_out_d;
            b_out_q      <= b_out_d;
            macc_clear_q <= macc_clear_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
        end
    end
endmodule
